// File: rtl/axi_lite_master_pkg.sv
// Shared AXI types for the AXI-lite master: response codes and one-hot FSM states.
package axi_lite_master_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [5:0] {
        IDLE    = 6'b000001,
        RD_ADDR = 6'b000010,
        RD_DATA = 6'b000100,
        WR_REQ  = 6'b001000,
        WR_RESP = 6'b010000,
        RSP     = 6'b100000
    } state_t;

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-lite initiator bridging a simple request/response port.
// Optional per-phase abort timer enabled with `define AXI_MST_TIMEOUT_EN.
module axi_lite_master
    import axi_lite_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_wen_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_wstrb_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    input  logic        rsp_ready_i,
    output logic        mst_ar_valid_o,
    input  logic        mst_ar_ready_i,
    output logic [31:0] mst_ar_addr_o,
    input  logic        mst_r_valid_i,
    output logic        mst_r_ready_o,
    input  logic [31:0] mst_r_data_i,
    input  axi_resp_t   mst_r_resp_i,
    output logic        mst_aw_valid_o,
    input  logic        mst_aw_ready_i,
    output logic [31:0] mst_aw_addr_o,
    output logic        mst_w_valid_o,
    input  logic        mst_w_ready_i,
    output logic [31:0] mst_w_data_o,
    output logic [3:0]  mst_w_strb_o,
    input  logic        mst_b_valid_i,
    output logic        mst_b_ready_o,
    input  axi_resp_t   mst_b_resp_i
);

    state_t      state, next;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic        aw_done, w_done;
    logic        req_hs, ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic        timeout, abort;

    // All AXI valid/ready outputs decode registered state only.
    assign req_ready_o    = (state == IDLE) && !rst_i;
    assign mst_ar_valid_o = (state == RD_ADDR);
    assign mst_r_ready_o  = (state == RD_DATA);
    assign mst_aw_valid_o = (state == WR_REQ) && !aw_done;
    assign mst_w_valid_o  = (state == WR_REQ) && !w_done;
    assign mst_b_ready_o  = (state == WR_RESP);
    assign rsp_valid_o    = (state == RSP);
    assign mst_ar_addr_o  = addr_q;
    assign mst_aw_addr_o  = addr_q;
    assign mst_w_data_o   = wdata_q;
    assign mst_w_strb_o   = wstrb_q;

    assign req_hs = req_valid_i && req_ready_o;
    assign ar_hs  = mst_ar_valid_o && mst_ar_ready_i;
    assign r_hs   = mst_r_ready_o && mst_r_valid_i;
    assign aw_hs  = mst_aw_valid_o && mst_aw_ready_i;
    assign w_hs   = mst_w_valid_o && mst_w_ready_i;
    assign b_hs   = mst_b_ready_o && mst_b_valid_i;

`ifdef AXI_MST_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_cnt <= '0;
        end else if (next != state) begin
            tmo_cnt <= '0;
        end else if (state inside {RD_ADDR, RD_DATA, WR_REQ, WR_RESP}) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    // Fires in the last of TIMEOUT_CYC cycles spent in one waiting phase.
    assign timeout = (tmo_cnt == 8'(TIMEOUT_CYC - 1));
`else
    // Timer absent: phases wait indefinitely; TIMEOUT_CYC kept for port-map compatibility.
    assign timeout = 1'b0 && (TIMEOUT_CYC != 0);
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next  = state;
        abort = 1'b0;
        case (state)
            IDLE: begin
                if (req_hs) next = req_wen_i ? WR_REQ : RD_ADDR;
            end
            RD_ADDR: begin
                if (ar_hs) next = RD_DATA;
                else if (timeout) begin next = RSP; abort = 1'b1; end
            end
            RD_DATA: begin
                if (r_hs) next = RSP;
                else if (timeout) begin next = RSP; abort = 1'b1; end
            end
            WR_REQ: begin
                if ((aw_done || aw_hs) && (w_done || w_hs)) next = WR_RESP;
                else if (timeout) begin next = RSP; abort = 1'b1; end
            end
            WR_RESP: begin
                if (b_hs) next = RSP;
                else if (timeout) begin next = RSP; abort = 1'b1; end
            end
            RSP: begin
                if (rsp_ready_i) next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            if (req_hs) begin
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                wstrb_q <= req_wstrb_i;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
            if (r_hs) begin
                rsp_rdata_o <= mst_r_data_i;
                rsp_err_o   <= (mst_r_resp_i != OKAY);
            end
            if (b_hs) begin
                rsp_rdata_o <= '0;
                rsp_err_o   <= (mst_b_resp_i != OKAY);
            end
            if (abort) begin
                rsp_rdata_o <= '0;
                rsp_err_o   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed self-checking bench for axi_lite_master with a configurable-delay AXI-lite slave.
module tb_axi_lite_master;
    import axi_lite_master_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_valid_i, req_ready_o, req_wen_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic [3:0]  req_wstrb_i;
    logic        rsp_valid_o, rsp_err_o, rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        mst_ar_valid_o, mst_ar_ready_i;
    logic [31:0] mst_ar_addr_o;
    logic        mst_r_valid_i, mst_r_ready_o;
    logic [31:0] mst_r_data_i;
    axi_resp_t   mst_r_resp_i;
    logic        mst_aw_valid_o, mst_aw_ready_i;
    logic [31:0] mst_aw_addr_o;
    logic        mst_w_valid_o, mst_w_ready_i;
    logic [31:0] mst_w_data_o;
    logic [3:0]  mst_w_strb_o;
    logic        mst_b_valid_i, mst_b_ready_o;
    axi_resp_t   mst_b_resp_i;

    int checks = 0;
    int errors = 0;

    int          ar_delay, r_delay, aw_delay, w_delay, b_delay;
    bit          ar_never;
    logic [31:0] mem_word;
    axi_resp_t   r_resp_cfg, b_resp_cfg;
    int          ar_cnt, aw_cnt, w_cnt;
    logic [31:0] ar_addr_seen, aw_addr_seen, w_data_seen;
    logic [3:0]  w_strb_seen;

    always #5 clk = ~clk;

    axi_lite_master #(.TIMEOUT_CYC(16)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_wen_i(req_wen_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .rsp_ready_i(rsp_ready_i),
        .mst_ar_valid_o(mst_ar_valid_o), .mst_ar_ready_i(mst_ar_ready_i), .mst_ar_addr_o(mst_ar_addr_o),
        .mst_r_valid_i(mst_r_valid_i), .mst_r_ready_o(mst_r_ready_o), .mst_r_data_i(mst_r_data_i),
        .mst_r_resp_i(mst_r_resp_i),
        .mst_aw_valid_o(mst_aw_valid_o), .mst_aw_ready_i(mst_aw_ready_i), .mst_aw_addr_o(mst_aw_addr_o),
        .mst_w_valid_o(mst_w_valid_o), .mst_w_ready_i(mst_w_ready_i), .mst_w_data_o(mst_w_data_o),
        .mst_w_strb_o(mst_w_strb_o),
        .mst_b_valid_i(mst_b_valid_i), .mst_b_ready_o(mst_b_ready_o), .mst_b_resp_i(mst_b_resp_i)
    );

    // Slave: each channel answers after <delay> cycles of the master's valid/ready being up.
    initial begin
        int ar_w, r_w, aw_w, w_w, b_w;
        ar_w = 0; r_w = 0; aw_w = 0; w_w = 0; b_w = 0;
        mst_ar_ready_i = 0; mst_r_valid_i = 0; mst_r_data_i = '0; mst_r_resp_i = OKAY;
        mst_aw_ready_i = 0; mst_w_ready_i = 0; mst_b_valid_i = 0; mst_b_resp_i = OKAY;
        forever begin
            @(posedge clk); #2;
            if (mst_ar_valid_o && !ar_never && ar_w >= ar_delay) mst_ar_ready_i = 1;
            else begin mst_ar_ready_i = 0; ar_w = mst_ar_valid_o ? ar_w + 1 : 0; end
            if (mst_aw_valid_o && aw_w >= aw_delay) mst_aw_ready_i = 1;
            else begin mst_aw_ready_i = 0; aw_w = mst_aw_valid_o ? aw_w + 1 : 0; end
            if (mst_w_valid_o && w_w >= w_delay) mst_w_ready_i = 1;
            else begin mst_w_ready_i = 0; w_w = mst_w_valid_o ? w_w + 1 : 0; end
            if (mst_r_ready_o && r_w >= r_delay) begin
                mst_r_valid_i = 1; mst_r_data_i = mem_word; mst_r_resp_i = r_resp_cfg;
            end else begin
                mst_r_valid_i = 0; r_w = mst_r_ready_o ? r_w + 1 : 0;
            end
            if (mst_b_ready_o && b_w >= b_delay) begin
                mst_b_valid_i = 1; mst_b_resp_i = b_resp_cfg;
            end else begin
                mst_b_valid_i = 0; b_w = mst_b_ready_o ? b_w + 1 : 0;
            end
        end
    end

    always @(negedge clk) begin
        if (mst_ar_valid_o && mst_ar_ready_i) begin ar_cnt++; ar_addr_seen = mst_ar_addr_o; end
        if (mst_aw_valid_o && mst_aw_ready_i) begin aw_cnt++; aw_addr_seen = mst_aw_addr_o; end
        if (mst_w_valid_o && mst_w_ready_i) begin
            w_cnt++; w_data_seen = mst_w_data_o; w_strb_seen = mst_w_strb_o;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic slave_defaults();
        ar_delay = 0; r_delay = 0; aw_delay = 0; w_delay = 0; b_delay = 0; ar_never = 0;
        r_resp_cfg = OKAY; b_resp_cfg = OKAY; mem_word = '0;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
    endtask

    task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb);
        req_valid_i = 1; req_wen_i = wen; req_addr_i = addr; req_wdata_i = wdata; req_wstrb_i = wstrb;
        tick();
        req_valid_i = 0;
    endtask

    task automatic wait_rsp(input int start, output int lat);
        lat = start;
        while (!rsp_valid_o && lat < 200) begin tick(); lat++; end
    endtask

    task automatic consume();
        rsp_ready_i = 1; tick(); rsp_ready_i = 0;
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++;
        if (req_ready_o !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b expected 0", req_ready_o); end
        checks++;
        if ({mst_ar_valid_o, mst_aw_valid_o, mst_w_valid_o, mst_r_ready_o, mst_b_ready_o, rsp_valid_o} !== 6'b0) begin
            errors++; $display("FAIL rst_valids: got %b expected 000000",
                {mst_ar_valid_o, mst_aw_valid_o, mst_w_valid_o, mst_r_ready_o, mst_b_ready_o, rsp_valid_o});
        end
        checks++;
        if ({rsp_err_o, rsp_rdata_o} !== 33'b0) begin errors++; $display("FAIL rst_rsp: got %b/%h expected 0/0", rsp_err_o, rsp_rdata_o); end
        rst_i = 0; #1;
        checks++;
        if (req_ready_o !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b expected 1", req_ready_o); end
    endtask

    task automatic test_read_basic();
        int lat;
        slave_defaults(); mem_word = 32'hDEADBEEF;
        tick();
        issue(1'b0, 32'h8000_0000, '0, '0);
        wait_rsp(1, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL rd_latency: got %0d expected 3", lat); end
        checks++;
        if (rsp_rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", rsp_rdata_o); end
        checks++;
        if (rsp_err_o !== 1'b0) begin errors++; $display("FAIL rd_err: got %b expected 0", rsp_err_o); end
        checks++;
        if (ar_cnt !== 1 || ar_addr_seen !== 32'h8000_0000) begin
            errors++; $display("FAIL rd_ar: got cnt %0d addr %h expected cnt 1 addr 80000000", ar_cnt, ar_addr_seen);
        end
        consume();
        checks++;
        if ({rsp_valid_o, req_ready_o} !== 2'b01) begin errors++; $display("FAIL rd_return_idle: got %b expected 01", {rsp_valid_o, req_ready_o}); end
    endtask

    task automatic test_write_skew();
        int lat;
        slave_defaults(); w_delay = 2;
        issue(1'b1, 32'h8000_0010, 32'h1234_5678, 4'b0011);
        checks++;
        if ({mst_aw_valid_o, mst_w_valid_o} !== 2'b11) begin errors++; $display("FAIL wr_entry_valids: got %b expected 11", {mst_aw_valid_o, mst_w_valid_o}); end
        tick();
        checks++;
        if ({mst_aw_valid_o, mst_w_valid_o} !== 2'b01) begin errors++; $display("FAIL wr_aw_drop: got %b expected 01", {mst_aw_valid_o, mst_w_valid_o}); end
        wait_rsp(2, lat);
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL wr_skew_latency: got %0d expected 5", lat); end
        checks++;
        if (aw_cnt !== 1 || w_cnt !== 1) begin errors++; $display("FAIL wr_hs_count: got aw %0d w %0d expected 1 1", aw_cnt, w_cnt); end
        checks++;
        if (aw_addr_seen !== 32'h8000_0010 || w_data_seen !== 32'h1234_5678 || w_strb_seen !== 4'b0011) begin
            errors++; $display("FAIL wr_payload: got %h %h %b expected 80000010 12345678 0011", aw_addr_seen, w_data_seen, w_strb_seen);
        end
        checks++;
        if ({rsp_err_o, rsp_rdata_o} !== 33'b0) begin errors++; $display("FAIL wr_rsp: got %b/%h expected 0/0", rsp_err_o, rsp_rdata_o); end
        consume();
    endtask

    task automatic test_back_to_back();
        int lat;
        slave_defaults(); mem_word = 32'hA5A5_0001;
        issue(1'b0, 32'h0000_0004, '0, '0);
        wait_rsp(1, lat);
        checks++;
        if (lat !== 3 || rsp_rdata_o !== 32'hA5A5_0001) begin errors++; $display("FAIL b2b_read: got lat %0d data %h expected 3 a5a50001", lat, rsp_rdata_o); end
        consume();
        issue(1'b1, 32'h0000_0008, 32'hFFFF_0000, 4'hF);
        wait_rsp(1, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL b2b_write_latency: got %0d expected 3", lat); end
        checks++;
        if (rsp_rdata_o !== 32'h0 || aw_cnt !== 1 || w_cnt !== 1) begin
            errors++; $display("FAIL b2b_write: got data %h aw %0d w %0d expected 0 1 1", rsp_rdata_o, aw_cnt, w_cnt);
        end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        slave_defaults(); r_delay = 7; mem_word = 32'hCAFE_F00D;
        issue(1'b0, 32'h8000_0040, '0, '0);
        wait_rsp(1, lat);
        checks++;
        if (lat !== 10) begin errors++; $display("FAIL bp_latency: got %0d expected 10", lat); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({rsp_valid_o, rsp_rdata_o} !== {1'b1, 32'hCAFE_F00D}) begin
                errors++; $display("FAIL bp_hold%0d: got %b/%h expected 1/cafef00d", i, rsp_valid_o, rsp_rdata_o);
            end
        end
        checks++;
        if (ar_cnt !== 1) begin errors++; $display("FAIL bp_ar_count: got %0d expected 1", ar_cnt); end
        consume();
    endtask

    task automatic test_errors();
        int lat;
        slave_defaults(); b_resp_cfg = SLVERR;
        issue(1'b1, 32'h10, 32'h1, 4'h1);
        wait_rsp(1, lat);
        checks++;
        if (rsp_err_o !== 1'b1) begin errors++; $display("FAIL b_slverr: got %b expected 1", rsp_err_o); end
        consume();
        r_resp_cfg = DECERR; mem_word = 32'h1111_2222;
        issue(1'b0, 32'h20, '0, '0);
        wait_rsp(1, lat);
        checks++;
        if (rsp_err_o !== 1'b1) begin errors++; $display("FAIL r_decerr: got %b expected 1", rsp_err_o); end
        consume();
        r_resp_cfg = OKAY;
        issue(1'b0, 32'h24, '0, '0);
        wait_rsp(1, lat);
        checks++;
        if (rsp_err_o !== 1'b0) begin errors++; $display("FAIL err_clears: got %b expected 0", rsp_err_o); end
        consume();
    endtask

    task automatic test_reset_mid();
        int lat;
        slave_defaults(); r_delay = 3;
        issue(1'b0, 32'h30, '0, '0);
        tick();
        checks++;
        if (mst_r_ready_o !== 1'b1) begin errors++; $display("FAIL mid_in_rd_data: got %b expected 1", mst_r_ready_o); end
        #2 rst_i = 1; #1;
        checks++;
        if ({mst_ar_valid_o, mst_aw_valid_o, mst_w_valid_o, mst_r_ready_o, mst_b_ready_o, rsp_valid_o, req_ready_o} !== 7'b0) begin
            errors++; $display("FAIL mid_rst_outputs: got %b expected 0000000",
                {mst_ar_valid_o, mst_aw_valid_o, mst_w_valid_o, mst_r_ready_o, mst_b_ready_o, rsp_valid_o, req_ready_o});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({rsp_valid_o, rsp_rdata_o} !== 33'b0) begin errors++; $display("FAIL mid_no_rsp%0d: got %b/%h expected 0/0", i, rsp_valid_o, rsp_rdata_o); end
        end
        rst_i = 0; #1;
        checks++;
        if (req_ready_o !== 1'b1) begin errors++; $display("FAIL mid_ready_after: got %b expected 1", req_ready_o); end
        slave_defaults(); mem_word = 32'h0BAD_F00D;
        issue(1'b0, 32'h8000_0020, '0, '0);
        wait_rsp(1, lat);
        checks++;
        if (lat !== 3 || rsp_rdata_o !== 32'h0BAD_F00D || ar_cnt !== 1) begin
            errors++; $display("FAIL mid_recover: got lat %0d data %h ar %0d expected 3 0badf00d 1", lat, rsp_rdata_o, ar_cnt);
        end
        consume();
    endtask

`ifdef AXI_MST_TIMEOUT_EN
    task automatic test_timeout();
        int lat;
        slave_defaults(); ar_never = 1;
        issue(1'b0, 32'h50, '0, '0);
        wait_rsp(1, lat);
        checks++;
        if (lat !== 17) begin errors++; $display("FAIL to_latency: got %0d expected 17", lat); end
        checks++;
        if ({rsp_err_o, rsp_rdata_o, mst_ar_valid_o} !== {1'b1, 32'h0, 1'b0}) begin
            errors++; $display("FAIL to_rsp: got err %b data %h arvalid %b expected 1 0 0", rsp_err_o, rsp_rdata_o, mst_ar_valid_o);
        end
        consume();
        ar_never = 0;
    endtask
`endif

    initial begin
        rst_i = 1; req_valid_i = 0; req_wen_i = 0; req_addr_i = '0; req_wdata_i = '0;
        req_wstrb_i = '0; rsp_ready_i = 0;
        slave_defaults();
        test_reset();
        test_read_basic();
        test_write_skew();
        test_back_to_back();
        test_backpressure();
        test_errors();
        test_reset_mid();
`ifdef AXI_MST_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
